descriptor_arbiter: RTL and testbench
=====================================

# descriptor_arbiter

Arbitrates descriptors (40-bit tsntag + bufid) from up to PORT_NUM host-side requesters onto the single descriptor channel into the input queue. Time-sensitive (TS) requesters take strict priority over non-time-sensitive (NTS) requesters, with an anti-starvation limit on consecutive TS grants. Round-robin applies within each class. Each grant is held until the input queue acknowledges it; a timeout drops a grant that is never acknowledged, so the channel cannot lock.

## Interface
- PORT_NUM, 4, number of requesters (2..8)
- MAX_TS_BURST, 8, consecutive TS grants allowed while any NTS request is pending
- TIMEOUT_CYCLES, 1023, WAIT_ACK_S cycles before a grant is dropped
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous, active-low reset
- iv_port_is_ts  in  PORT_NUM  static config; bit i=1 marks port i as a TS requester
- iv_descriptor  in  40*PORT_NUM  port i uses bits [40i+39:40i]
- iv_descriptor_wr  in  PORT_NUM  per-port request level; held with the descriptor until acked
- ov_descriptor_ack  out  PORT_NUM  one-cycle ack to the granted port
- ov_descriptor  out  40  granted descriptor toward the input queue
- o_descriptor_wr  out  1  output valid level
- i_descriptor_ack  in  1  input-queue accept pulse
- o_timeout_err  out  1  one-cycle pulse when a grant is dropped
- ov_drop_cnt  out  16  saturating count of dropped grants

## Operation
- States: IDLE_S, WAIT_ACK_S, ACK_S.
- IDLE_S, with at least one request: choose a winner, register ov_descriptor and o_descriptor_wr=1, store the grant index, then go to WAIT_ACK_S. With no request, outputs stay 0.
- Winner selection:
  - If NTS requests are pending and burst_cnt == MAX_TS_BURST, take the NTS round-robin winner.
  - Otherwise, if any TS request is pending, take the TS round-robin winner.
  - Otherwise, take the NTS round-robin winner.
- Round robin: each class has its own pointer. The search starts at the pointer and wraps modulo PORT_NUM. After a grant in a class, that class pointer moves to grant+1 (wrapping).
- burst_cnt: +1 on each TS grant made while an NTS request is pending (saturates at MAX_TS_BURST). Cleared on an NTS grant or when no NTS request is pending.
- WAIT_ACK_S: ov_descriptor stays stable and o_descriptor_wr=1. Two exits:
  - i_descriptor_ack=1: clear ov_descriptor and o_descriptor_wr, set ov_descriptor_ack[grant]=1, go to ACK_S.
  - wait counter reaches TIMEOUT_CYCLES: same actions as ack, plus o_timeout_err=1 and ov_drop_cnt+1 (saturates at 16'hFFFF).
- ACK_S: lasts one cycle. Clear ov_descriptor_ack, ignore all requests, go to IDLE_S. This gives the requester time to drop its wr before the next sampling, so one request is never granted twice.
- i_descriptor_ack outside WAIT_ACK_S: ignored.
- iv_port_is_ts changes: allowed only while all requests are idle. Otherwise behaviour is undefined.
- Reset, including mid-grant: all outputs 0, ov_drop_cnt=0, both pointers 0, burst_cnt=0, wait counter 0, state IDLE_S. A pending grant is abandoned and no ack is issued.

## Timing
- Request seen at edge N: o_descriptor_wr=1 after edge N+1.
- i_descriptor_ack sampled at edge M: ov_descriptor_ack high during cycle M..M+1, wr low from M onward, IDLE_S from M+1.
- Minimum grant period: 3 cycles (IDLE_S, WAIT_ACK_S, ACK_S) when the ack arrives in the first WAIT_ACK_S cycle.
- Timeout: the drop happens at the edge ending the TIMEOUT_CYCLES-th WAIT_ACK_S cycle. Wait counter width is clog2(TIMEOUT_CYCLES+1).
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Shared package (tsn_desc_pkg):
  - DESC_W=40
  - state localparams IDLE_S/WAIT_ACK_S/ACK_S
  - drop counter width 16
- Sub-module rr_pick: combinational round-robin picker. Takes a PORT_NUM-bit request mask and a pointer; returns a valid flag and the winner index. Instantiated twice, with masks wr&is_ts and wr&~is_ts.
- Top level holds the FSM, pointers, burst_cnt, wait counter and drop counter.

## Test plan
- Single port: port2 (NTS) sends 40'h00_1234_5678, acked on the first WAIT_ACK_S cycle → ov_descriptor=40'h00_1234_5678 one cycle after the request; ov_descriptor_ack=4'b0100 for one cycle; grant period is 3 cycles.
- Priority: ports 0 (TS) and 1 (NTS) both request, queue always acks → port0 is granted first, then port1.
- Round robin: TS ports 0 and 3 request continuously → grants alternate 0,3,0,3.
- Starvation: TS port0 requests continuously, NTS port1 requests, MAX_TS_BURST=8 → eight port0 grants, then one port1 grant, then burst_cnt restarts.
- Timeout: i_descriptor_ack held 0 → after 1023 WAIT_ACK_S cycles: o_timeout_err pulses, ov_drop_cnt=1, requester is acked, arbiter returns to IDLE_S. Also check ov_drop_cnt saturates at 16'hFFFF.
- Reset in WAIT_ACK_S: all outputs 0 immediately and no ack pulse; after reset release the request is re-granted.

Source files
------------

// File: rtl/tsn_desc_pkg.sv
// rtl/tsn_desc_pkg.sv - shared descriptor widths and arbiter state encoding
package tsn_desc_pkg;

    localparam int DESC_W     = 40;
    localparam int DROP_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE_S     = 2'd0,
        WAIT_ACK_S = 2'd1,
        ACK_S      = 2'd2
    } arb_state_t;

endpackage

// File: rtl/descriptor_arbiter_if.sv
// rtl/descriptor_arbiter_if.sv - requester and input-queue descriptor channel bundle
interface descriptor_arbiter_if
    import tsn_desc_pkg::*;
#(
    parameter int PORT_NUM = 4
);

    logic [PORT_NUM-1:0]        iv_port_is_ts;
    logic [DESC_W*PORT_NUM-1:0] iv_descriptor;
    logic [PORT_NUM-1:0]        iv_descriptor_wr;
    logic [PORT_NUM-1:0]        ov_descriptor_ack;
    logic [DESC_W-1:0]          ov_descriptor;
    logic                       o_descriptor_wr;
    logic                       i_descriptor_ack;
    logic                       o_timeout_err;
    logic [DROP_CNT_W-1:0]      ov_drop_cnt;

    modport slave (
        input  iv_port_is_ts,
        input  iv_descriptor,
        input  iv_descriptor_wr,
        input  i_descriptor_ack,
        output ov_descriptor_ack,
        output ov_descriptor,
        output o_descriptor_wr,
        output o_timeout_err,
        output ov_drop_cnt
    );

    modport master (
        output iv_port_is_ts,
        output iv_descriptor,
        output iv_descriptor_wr,
        output i_descriptor_ack,
        input  ov_descriptor_ack,
        input  ov_descriptor,
        input  o_descriptor_wr,
        input  o_timeout_err,
        input  ov_drop_cnt
    );

endinterface

// File: rtl/descriptor_arbiter_rr_pick.sv
// rtl/descriptor_arbiter_rr_pick.sv - combinational round-robin picker starting at ptr
module rr_pick #(
    parameter  int PORT_NUM = 4,
    localparam int IDX_W    = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1
) (
    input  logic [PORT_NUM-1:0] req,
    input  logic [IDX_W-1:0]    ptr,
    output logic                valid,
    output logic [IDX_W-1:0]    idx
);

    int   cand;
    logic found;

    always_comb begin
        valid = |req;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        // ptr is always < PORT_NUM, so a single subtract wraps the search
        for (int k = 0; k < PORT_NUM; k++) begin
            cand = int'(ptr) + k;
            if (cand >= PORT_NUM) begin
                cand = cand - PORT_NUM;
            end
            if (!found && req[cand]) begin
                idx   = IDX_W'(cand);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/descriptor_arbiter.sv
// rtl/descriptor_arbiter.sv - TS/NTS priority arbiter with anti-starvation, ack handshake and timeout
module descriptor_arbiter
    import tsn_desc_pkg::*;
#(
    parameter int PORT_NUM       = 4,
    parameter int MAX_TS_BURST   = 8,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    descriptor_arbiter_if.slave  bus
);

    localparam int IDX_W   = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;
    localparam int WAIT_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int BURST_W = $clog2(MAX_TS_BURST + 1);

    arb_state_t             state_q, state_d;
    logic [IDX_W-1:0]       grant_q, grant_d;
    logic [IDX_W-1:0]       ptr_ts_q, ptr_ts_d;
    logic [IDX_W-1:0]       ptr_nts_q, ptr_nts_d;
    logic [BURST_W-1:0]     burst_q, burst_d;
    logic [WAIT_W-1:0]      wait_q, wait_d;
    logic [DESC_W-1:0]      desc_q, desc_d;
    logic                   wr_q, wr_d;
    logic [PORT_NUM-1:0]    ack_q, ack_d;
    logic                   err_q, err_d;
    logic [DROP_CNT_W-1:0]  drop_q, drop_d;

    logic [PORT_NUM-1:0]    ts_mask, nts_mask;
    logic                   ts_valid, nts_valid;
    logic [IDX_W-1:0]       ts_idx, nts_idx;
    logic                   grant_ts, grant_nts;
    logic [IDX_W-1:0]       sel_idx;

    assign ts_mask  = bus.iv_descriptor_wr &  bus.iv_port_is_ts;
    assign nts_mask = bus.iv_descriptor_wr & ~bus.iv_port_is_ts;

    rr_pick #(.PORT_NUM(PORT_NUM)) u_pick_ts (
        .req   (ts_mask),
        .ptr   (ptr_ts_q),
        .valid (ts_valid),
        .idx   (ts_idx)
    );

    rr_pick #(.PORT_NUM(PORT_NUM)) u_pick_nts (
        .req   (nts_mask),
        .ptr   (ptr_nts_q),
        .valid (nts_valid),
        .idx   (nts_idx)
    );

    function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] idx);
        return (int'(idx) == PORT_NUM - 1) ? '0 : idx + IDX_W'(1);
    endfunction

    // NTS wins only when starved; otherwise TS has strict priority
    always_comb begin
        grant_nts = 1'b0;
        grant_ts  = 1'b0;
        if (nts_valid && (burst_q == BURST_W'(MAX_TS_BURST))) begin
            grant_nts = 1'b1;
        end else if (ts_valid) begin
            grant_ts = 1'b1;
        end else if (nts_valid) begin
            grant_nts = 1'b1;
        end
        sel_idx = grant_ts ? ts_idx : nts_idx;
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        ptr_ts_d  = ptr_ts_q;
        ptr_nts_d = ptr_nts_q;
        burst_d   = burst_q;
        wait_d    = wait_q;
        desc_d    = desc_q;
        wr_d      = wr_q;
        ack_d     = '0;
        err_d     = 1'b0;
        drop_d    = drop_q;

        case (state_q)
            IDLE_S: begin
                if (!nts_valid) begin
                    burst_d = '0;
                end
                if (grant_ts || grant_nts) begin
                    desc_d  = bus.iv_descriptor[int'(sel_idx)*DESC_W +: DESC_W];
                    wr_d    = 1'b1;
                    grant_d = sel_idx;
                    wait_d  = '0;
                    state_d = WAIT_ACK_S;
                    if (grant_ts) begin
                        ptr_ts_d = next_ptr(sel_idx);
                        if (nts_valid && (burst_q != BURST_W'(MAX_TS_BURST))) begin
                            burst_d = burst_q + BURST_W'(1);
                        end
                    end else begin
                        ptr_nts_d = next_ptr(sel_idx);
                        burst_d   = '0;
                    end
                end
            end

            WAIT_ACK_S: begin
                if (bus.i_descriptor_ack || (wait_q == WAIT_W'(TIMEOUT_CYCLES - 1))) begin
                    desc_d         = '0;
                    wr_d           = 1'b0;
                    ack_d[grant_q] = 1'b1;
                    wait_d         = '0;
                    state_d        = ACK_S;
                    if (!bus.i_descriptor_ack) begin
                        err_d = 1'b1;
                        if (drop_q != {DROP_CNT_W{1'b1}}) begin
                            drop_d = drop_q + DROP_CNT_W'(1);
                        end
                    end
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end

            ACK_S: begin
                // requester uses this cycle to drop wr before IDLE_S samples again
                state_d = IDLE_S;
            end

            default: begin
                state_d = IDLE_S;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE_S;
            grant_q   <= '0;
            ptr_ts_q  <= '0;
            ptr_nts_q <= '0;
            burst_q   <= '0;
            wait_q    <= '0;
            desc_q    <= '0;
            wr_q      <= 1'b0;
            ack_q     <= '0;
            err_q     <= 1'b0;
            drop_q    <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            ptr_ts_q  <= ptr_ts_d;
            ptr_nts_q <= ptr_nts_d;
            burst_q   <= burst_d;
            wait_q    <= wait_d;
            desc_q    <= desc_d;
            wr_q      <= wr_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            drop_q    <= drop_d;
        end
    end

    assign bus.ov_descriptor     = desc_q;
    assign bus.o_descriptor_wr   = wr_q;
    assign bus.ov_descriptor_ack = ack_q;
    assign bus.o_timeout_err     = err_q;
    assign bus.ov_drop_cnt       = drop_q;

endmodule

// File: tb/tb_descriptor_arbiter.sv
// tb/tb_descriptor_arbiter.sv - scoreboard bench for descriptor_arbiter
module tb_descriptor_arbiter;

    localparam int NP = 4;

    typedef struct {
        int          port;
        logic [39:0] desc;
        bit          timeout;
        int          wait_cyc;
        int          gap;
    } exp_t;

    logic i_clk;
    logic i_rst_n;

    descriptor_arbiter_if #(.PORT_NUM(NP)) bus ();

    descriptor_arbiter #(
        .PORT_NUM       (NP),
        .MAX_TS_BURST   (8),
        .TIMEOUT_CYCLES (1023)
    ) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    exp_t        sb [$];
    logic [39:0] pq [NP][$];
    bit          auto_ack;
    int          n_tests;
    int          n_fail;

    bit prev_wr;
    int wr_cyc;
    int cyc;
    int last_rise;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic req(input int port, input logic [39:0] d);
        pq[port].push_back(d);
    endtask

    task automatic expect_grant(input int port, input logic [39:0] d, input bit to,
                                input int waitc, input int gap);
        exp_t e;
        e.port = port; e.desc = d; e.timeout = to; e.wait_cyc = waitc; e.gap = gap;
        sb.push_back(e);
    endtask

    function automatic bit all_idle();
        bit idle;
        idle = (sb.size() == 0);
        for (int i = 0; i < NP; i++) begin
            if (pq[i].size() != 0) idle = 1'b0;
        end
        return idle;
    endfunction

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while (!all_idle() && n < budget) begin
            @(negedge i_clk);
            n++;
        end
        chk(name, {63'd0, all_idle()}, 64'd1);
        repeat (2) @(negedge i_clk);
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
    endtask

    // requesters and input-queue responder
    initial begin
        bus.iv_port_is_ts    = 4'b1001;
        bus.iv_descriptor    = '0;
        bus.iv_descriptor_wr = '0;
        bus.i_descriptor_ack = 1'b0;
        forever begin
            @(negedge i_clk);
            for (int i = 0; i < NP; i++) begin
                if (bus.ov_descriptor_ack[i] && pq[i].size() != 0) void'(pq[i].pop_front());
                if (pq[i].size() != 0) begin
                    bus.iv_descriptor_wr[i]        = 1'b1;
                    bus.iv_descriptor[i*40 +: 40]  = pq[i][0];
                end else begin
                    bus.iv_descriptor_wr[i]        = 1'b0;
                    bus.iv_descriptor[i*40 +: 40]  = '0;
                end
            end
            bus.i_descriptor_ack = auto_ack && bus.o_descriptor_wr;
        end
    end

    // monitor
    initial begin
        logic [3:0] exp_ack;
        prev_wr = 1'b0; wr_cyc = 0; cyc = 0; last_rise = 0;
        forever begin
            @(negedge i_clk);
            cyc++;
            if (!i_rst_n) begin
                prev_wr = 1'b0;
                wr_cyc  = 0;
            end else begin
                if (bus.o_descriptor_wr && !prev_wr) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_grant", 64'd1, 64'd0);
                    end else begin
                        chk("grant_desc", bus.ov_descriptor, sb[0].desc);
                        if (sb[0].gap > 0) chk("grant_period", cyc - last_rise, sb[0].gap);
                    end
                    last_rise = cyc;
                    wr_cyc    = 0;
                end
                if (bus.o_descriptor_wr) wr_cyc++;
                if (bus.ov_descriptor_ack != '0) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_ack", {60'd0, bus.ov_descriptor_ack}, 64'd0);
                    end else begin
                        exp_ack = 4'b0001 << sb[0].port;
                        chk("ack_port", {60'd0, bus.ov_descriptor_ack}, {60'd0, exp_ack});
                        chk("timeout_err", {63'd0, bus.o_timeout_err}, {63'd0, sb[0].timeout});
                        chk("wait_cycles", wr_cyc, sb[0].wait_cyc);
                        void'(sb.pop_front());
                    end
                end
                prev_wr = bus.o_descriptor_wr;
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        auto_ack = 1'b1;
        i_rst_n  = 1'b0;
        repeat (3) @(negedge i_clk);
        chk("rst_wr",   {63'd0, bus.o_descriptor_wr}, 64'd0);
        chk("rst_desc", bus.ov_descriptor, 64'd0);
        chk("rst_ack",  {60'd0, bus.ov_descriptor_ack}, 64'd0);
        chk("rst_err",  {63'd0, bus.o_timeout_err}, 64'd0);
        chk("rst_drop", bus.ov_drop_cnt, 64'd0);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        // single NTS port, two back-to-back descriptors
        expect_grant(2, 40'h00_1234_5678, 1'b0, 1, 0);
        expect_grant(2, 40'h00_1234_5679, 1'b0, 1, 3);
        req(2, 40'h00_1234_5678);
        req(2, 40'h00_1234_5679);
        drain("single_drain", 200);

        // TS beats NTS
        do_reset();
        expect_grant(0, 40'h0A_0000_0001, 1'b0, 1, 0);
        expect_grant(1, 40'h1B_0000_0002, 1'b0, 1, 3);
        req(0, 40'h0A_0000_0001);
        req(1, 40'h1B_0000_0002);
        drain("prio_drain", 200);

        // round robin within TS class
        do_reset();
        expect_grant(0, 40'hC0_0000_0000, 1'b0, 1, 0);
        expect_grant(3, 40'hC3_0000_0000, 1'b0, 1, 3);
        expect_grant(0, 40'hC0_0000_0001, 1'b0, 1, 3);
        expect_grant(3, 40'hC3_0000_0001, 1'b0, 1, 3);
        req(0, 40'hC0_0000_0000); req(0, 40'hC0_0000_0001);
        req(3, 40'hC3_0000_0000); req(3, 40'hC3_0000_0001);
        drain("rr_drain", 200);

        // starvation limit: 8 TS, 1 NTS, then the burst restarts
        do_reset();
        for (int k = 0; k < 8; k++) expect_grant(0, 40'h50_0000_0000 + k, 1'b0, 1, (k == 0) ? 0 : 3);
        expect_grant(1, 40'h51_0000_0000, 1'b0, 1, 3);
        expect_grant(0, 40'h50_0000_0008, 1'b0, 1, 3);
        expect_grant(0, 40'h50_0000_0009, 1'b0, 1, 3);
        expect_grant(1, 40'h51_0000_0001, 1'b0, 1, 3);
        for (int k = 0; k < 10; k++) req(0, 40'h50_0000_0000 + k);
        req(1, 40'h51_0000_0000);
        req(1, 40'h51_0000_0001);
        drain("starve_drain", 400);

        // timeout: the queue never acks
        do_reset();
        auto_ack = 1'b0;
        expect_grant(1, 40'hDE_AD00_0001, 1'b1, 1023, 0);
        req(1, 40'hDE_AD00_0001);
        drain("timeout_drain", 1200);
        chk("timeout_drop_cnt", bus.ov_drop_cnt, 64'd1);
        chk("timeout_err_clear", {63'd0, bus.o_timeout_err}, 64'd0);
        chk("timeout_idle_wr", {63'd0, bus.o_descriptor_wr}, 64'd0);

        // reset while waiting for ack, then re-grant
        expect_grant(3, 40'hBE_EF00_0003, 1'b0, 1, 0);
        req(3, 40'hBE_EF00_0003);
        repeat (8) @(negedge i_clk);
        chk("pre_reset_wr", {63'd0, bus.o_descriptor_wr}, 64'd1);
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("mid_rst_wr",   {63'd0, bus.o_descriptor_wr}, 64'd0);
        chk("mid_rst_desc", bus.ov_descriptor, 64'd0);
        chk("mid_rst_drop", bus.ov_drop_cnt, 64'd0);
        auto_ack = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge i_clk);
            chk("mid_rst_ack", {60'd0, bus.ov_descriptor_ack}, 64'd0);
        end
        i_rst_n = 1'b1;
        drain("regrant_drain", 200);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
